// File: rtl/usi_pkg.sv
// Shared USI definitions: UART transmit state encoding, dispatcher mode
// constants and the parity helper.
// Optional feature macro: USI_UART_PARITY_EN (adds the PARITY state).
package usi_pkg;

  // Mode codes shared with the USI dispatcher.
  localparam logic [1:0] USI_MODE_UART = 2'b00;
  localparam logic [1:0] USI_MODE_I2C  = 2'b01;
  localparam logic [1:0] USI_MODE_SPI  = 2'b10;

  typedef enum logic [2:0] {
    TX_IDLE     = 3'd0,
    TX_WAIT_CTS = 3'd1,
    TX_START    = 3'd2,
    TX_DATA     = 3'd3,
`ifdef USI_UART_PARITY_EN
    TX_PARITY   = 3'd4,
`endif
    TX_STOP     = 3'd5,
    TX_DONE     = 3'd6,
    TX_HOLD     = 3'd7
  } uart_tx_state_t;

  // Parity bit: XOR of all data bits, inverted for odd parity.
  function automatic logic uart_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/usi_baud_tick.sv
// Bit-period counter for the USI UART transmitter. Counts 0..CLKS_PER_BIT-1
// and flags the last cycle of each bit period with a one-cycle tick.
// Optional feature macro: none (USI_UART_PARITY_EN does not affect this block).
module usi_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Free-running bit-period counter, restarted whenever the FSM changes state.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Bit boundary: the cycle in which the counter holds its last value.
  assign tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/usi_uart_tx.sv
// USI UART transmit engine. Sends one byte per uart_en window with CTS flow
// control, then reports uart_done (or uart_err on CTS timeout) and holds
// until the dispatcher drops uart_en.
// Optional feature macro: USI_UART_PARITY_EN (parity_odd port + parity bit).
module usi_uart_tx
  import usi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CTS_TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       uart_en,
  input  logic [7:0] tx_data,
  input  logic       stop2,
`ifdef USI_UART_PARITY_EN
  input  logic       parity_odd,
`endif
  input  logic       cts_n,
  output logic       tx,
  output logic       uart_done,
  output logic       uart_err,
  output logic       tx_busy
);

  localparam int CTS_W = $clog2(CTS_TIMEOUT + 1);
  localparam logic [CTS_W-1:0] CTS_LAST = CTS_W'(CTS_TIMEOUT - 1);

  uart_tx_state_t   state_r, state_s;
  logic [7:0]       data_r, data_s;
  logic             stop2_r, stop2_s;
  logic             second_stop_r, second_stop_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic             err_r, err_s;
  logic [CTS_W-1:0] cts_cnt_r, cts_cnt_s;
`ifdef USI_UART_PARITY_EN
  logic             par_odd_r, par_odd_s;
`endif
  logic             tick_s;
  logic             clear_s;
  logic             tx_s;
  logic             busy_s;

  // Every state entry restarts the bit period.
  assign clear_s = (state_s != state_r);

  usi_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear_s),
    .tick  (tick_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r <= TX_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic, frame datapath updates and next-cycle line value.
  always_comb begin
    state_s       = state_r;
    data_s        = data_r;
    stop2_s       = stop2_r;
    second_stop_s = second_stop_r;
    bit_idx_s     = bit_idx_r;
    err_s         = err_r;
    cts_cnt_s     = cts_cnt_r;
`ifdef USI_UART_PARITY_EN
    par_odd_s     = par_odd_r;
`endif
    tx_s          = 1'b1;
    busy_s        = 1'b0;

    case (state_r)
      TX_IDLE: begin
        if (uart_en && !cts_n) begin
          data_s  = tx_data;
          stop2_s = stop2;
`ifdef USI_UART_PARITY_EN
          par_odd_s = parity_odd;
`endif
          state_s = TX_START;
        end else if (uart_en) begin
          cts_cnt_s = '0;
          state_s   = TX_WAIT_CTS;
        end else begin
          state_s = TX_IDLE;
        end
      end
      TX_WAIT_CTS: begin
        if (!uart_en) begin
          state_s = TX_IDLE;
        end else if (!cts_n) begin
          data_s  = tx_data;
          stop2_s = stop2;
`ifdef USI_UART_PARITY_EN
          par_odd_s = parity_odd;
`endif
          state_s = TX_START;
        end else if (tick_s) begin
          // Timeout is judged on bit boundaries, so latency is in bit periods.
          if (cts_cnt_r == CTS_LAST) begin
            err_s   = 1'b1;
            state_s = TX_DONE;
          end else begin
            cts_cnt_s = cts_cnt_r + {{(CTS_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_s = TX_WAIT_CTS;
        end
      end
      TX_START: begin
        if (!uart_en) begin
          state_s = TX_IDLE;
        end else if (tick_s) begin
          bit_idx_s = 3'd0;
          state_s   = TX_DATA;
        end else begin
          state_s = TX_START;
        end
      end
      TX_DATA: begin
        if (!uart_en) begin
          state_s = TX_IDLE;
        end else if (tick_s) begin
          if (bit_idx_r == 3'd7) begin
`ifdef USI_UART_PARITY_EN
            state_s = TX_PARITY;
`else
            second_stop_s = 1'b0;
            state_s       = TX_STOP;
`endif
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_s = TX_DATA;
        end
      end
`ifdef USI_UART_PARITY_EN
      TX_PARITY: begin
        if (!uart_en) begin
          state_s = TX_IDLE;
        end else if (tick_s) begin
          second_stop_s = 1'b0;
          state_s       = TX_STOP;
        end else begin
          state_s = TX_PARITY;
        end
      end
`endif
      TX_STOP: begin
        if (!uart_en) begin
          state_s = TX_IDLE;
        end else if (tick_s) begin
          if (stop2_r && !second_stop_r) begin
            second_stop_s = 1'b1;
          end else begin
            state_s = TX_DONE;
          end
        end else begin
          state_s = TX_STOP;
        end
      end
      TX_DONE: begin
        // The completion pulse was issued on entry; the error flag retires here.
        err_s   = 1'b0;
        state_s = TX_HOLD;
      end
      TX_HOLD: begin
        // Wait for the dispatcher to release the enable before re-arming.
        if (!uart_en) begin
          state_s = TX_IDLE;
        end else begin
          state_s = TX_HOLD;
        end
      end
      default: begin
        state_s = TX_IDLE;
      end
    endcase

    // Line value and busy flag follow the state being entered, so tx changes
    // on the same edge as the state.
    case (state_s)
      TX_START: begin
        tx_s   = 1'b0;
        busy_s = 1'b1;
      end
      TX_DATA: begin
        tx_s   = data_s[bit_idx_s];
        busy_s = 1'b1;
      end
`ifdef USI_UART_PARITY_EN
      TX_PARITY: begin
        tx_s   = uart_parity(data_s, par_odd_s);
        busy_s = 1'b1;
      end
`endif
      TX_STOP: begin
        tx_s   = 1'b1;
        busy_s = 1'b1;
      end
      default: begin
        tx_s   = 1'b1;
        busy_s = 1'b0;
      end
    endcase
  end

  // Frame datapath registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      data_r        <= 8'h00;
      stop2_r       <= 1'b0;
      second_stop_r <= 1'b0;
      bit_idx_r     <= 3'd0;
      err_r         <= 1'b0;
      cts_cnt_r     <= '0;
`ifdef USI_UART_PARITY_EN
      par_odd_r     <= 1'b0;
`endif
    end else begin
      data_r        <= data_s;
      stop2_r       <= stop2_s;
      second_stop_r <= second_stop_s;
      bit_idx_r     <= bit_idx_s;
      err_r         <= err_s;
      cts_cnt_r     <= cts_cnt_s;
`ifdef USI_UART_PARITY_EN
      par_odd_r     <= par_odd_s;
`endif
    end
  end

  // Registered outputs; done/err pulse on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      tx        <= 1'b1;
      uart_done <= 1'b0;
      uart_err  <= 1'b0;
      tx_busy   <= 1'b0;
    end else begin
      tx        <= tx_s;
      uart_done <= (state_s == TX_DONE) && (state_r != TX_DONE) && !err_s;
      uart_err  <= (state_s == TX_DONE) && (state_r != TX_DONE) && err_s;
      tx_busy   <= busy_s;
    end
  end

endmodule

// File: tb/tb_usi_uart_tx.sv
// Directed self-checking bench for usi_uart_tx (CLKS_PER_BIT=4, CTS_TIMEOUT=3).
// Build with +define+USI_UART_PARITY_EN to also exercise the parity bit.
module tb_usi_uart_tx;

  localparam int CPB = 4;
  localparam int CTO = 3;

  logic       clk;
  logic       n_rst;
  logic       uart_en;
  logic [7:0] tx_data;
  logic       stop2;
  logic       parity_odd;
  logic       cts_n;
  logic       tx;
  logic       uart_done;
  logic       uart_err;
  logic       tx_busy;

  int checks;
  int errors;

  usi_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .CTS_TIMEOUT (CTO)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .uart_en    (uart_en),
    .tx_data    (tx_data),
    .stop2      (stop2),
`ifdef USI_UART_PARITY_EN
    .parity_odd (parity_odd),
`endif
    .cts_n      (cts_n),
    .tx         (tx),
    .uart_done  (uart_done),
    .uart_err   (uart_err),
    .tx_busy    (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    n_rst = 1'b0; uart_en = 1'b0; cts_n = 1'b0; tx_data = 8'h00;
    stop2 = 1'b0; parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, uart_done, uart_err, tx_busy} !== 4'b1000) begin
      errors++;
      $display("FAIL reset: tx/done/err/busy=%b expected 1000", {tx, uart_done, uart_err, tx_busy});
    end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx, tx_busy} !== 2'b10) begin
      errors++;
      $display("FAIL idle_after_reset: tx/busy=%b expected 10", {tx, tx_busy});
    end
  endtask

  // Sends one frame and checks every cycle, then 10 HOLD cycles, then release.
  task automatic run_frame(input string name, input logic [7:0] data, input logic s2, input logic odd);
    logic [11:0] fb;
    int nbits;
    int total;
    logic exp_tx;
    fb = 12'hFFF;
    fb[0] = 1'b0;
    fb[8:1] = data;
    nbits = 1 + 8 + (s2 ? 2 : 1);
`ifdef USI_UART_PARITY_EN
    fb[9] = (^data) ^ odd;
    nbits = nbits + 1;
`endif
    total = nbits * CPB;
    tx_data = data; stop2 = s2; parity_odd = odd; cts_n = 1'b0;
    uart_en = 1'b1;
    for (int c = 0; c <= total + 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Inputs are latched at frame start; later changes must not matter.
        tx_data = ~data; stop2 = ~s2; parity_odd = ~odd; cts_n = 1'b1;
      end
      exp_tx = (c < total) ? fb[c / CPB] : 1'b1;
      checks++;
      if (tx !== exp_tx) begin
        errors++;
        $display("FAIL %s_tx: tx=%b expected %b at cycle %0d", name, tx, exp_tx, c);
      end
      checks++;
      if (uart_done !== (c == total)) begin
        errors++;
        $display("FAIL %s_done: uart_done=%b expected %b at cycle %0d", name, uart_done, (c == total), c);
      end
      checks++;
      if (uart_err !== 1'b0) begin
        errors++;
        $display("FAIL %s_err: uart_err=%b expected 0 at cycle %0d", name, uart_err, c);
      end
      checks++;
      if (tx_busy !== (c < total)) begin
        errors++;
        $display("FAIL %s_busy: tx_busy=%b expected %b at cycle %0d", name, tx_busy, (c < total), c);
      end
    end
    uart_en = 1'b0; cts_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx, uart_done, tx_busy} !== 3'b100) begin
      errors++;
      $display("FAIL %s_release: tx/done/busy=%b expected 100", name, {tx, uart_done, tx_busy});
    end
  endtask

  task automatic test_basic_frame();
    run_frame("basic_a5", 8'hA5, 1'b0, 1'b0);
  endtask

  task automatic test_two_stop();
    run_frame("stop2_3c", 8'h3C, 1'b1, 1'b0);
  endtask

  task automatic test_parity();
`ifdef USI_UART_PARITY_EN
    run_frame("parity_07", 8'h07, 1'b0, 1'b0);
    run_frame("parity_odd_07", 8'h07, 1'b1, 1'b1);
`endif
  endtask

  task automatic test_cts_timeout();
    int err_seen;
    err_seen = 0;
    tx_data = 8'h00; stop2 = 1'b0; cts_n = 1'b1;
    uart_en = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (uart_err === 1'b1) err_seen++;
      checks++;
      if (uart_err !== (c == CTO * CPB)) begin
        errors++;
        $display("FAIL cts_err: uart_err=%b expected %b at cycle %0d", uart_err, (c == CTO * CPB), c);
      end
      checks++;
      if ({tx, uart_done, tx_busy} !== 3'b100) begin
        errors++;
        $display("FAIL cts_line: tx/done/busy=%b expected 100 at cycle %0d", {tx, uart_done, tx_busy}, c);
      end
    end
    checks++;
    if (err_seen != 1) begin
      errors++;
      $display("FAIL cts_err_count: pulses=%0d expected 1", err_seen);
    end
    // Releasing the enable must bring the engine back to IDLE, which is
    // shown by an immediate start when CTS is then asserted.
    uart_en = 1'b0;
    repeat (2) @(negedge clk);
    cts_n = 1'b0; uart_en = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx, tx_busy} !== 2'b01) begin
      errors++;
      $display("FAIL cts_back_to_idle: tx/busy=%b expected 01", {tx, tx_busy});
    end
    uart_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx, tx_busy} !== 2'b10) begin
      errors++;
      $display("FAIL cts_abort_start: tx/busy=%b expected 10", {tx, tx_busy});
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    tx_data = 8'hA5; stop2 = 1'b0; cts_n = 1'b0;
    uart_en = 1'b1;
    // Cycles 16..19 carry data bit 3 (0 for 8'hA5).
    for (int c = 0; c <= 17; c++) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL abort_pre: tx=%b expected 0 during data bit 3", tx);
    end
    uart_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx, tx_busy} !== 2'b10) begin
      errors++;
      $display("FAIL abort_line: tx/busy=%b expected 10", {tx, tx_busy});
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if ({tx, uart_done, uart_err} !== 3'b100) begin
        errors++;
        $display("FAIL abort_quiet: tx/done/err=%b expected 100 at cycle %0d", {tx, uart_done, uart_err}, c);
      end
    end
  endtask

  task automatic test_reset_midframe();
    tx_data = 8'hA5; stop2 = 1'b0; cts_n = 1'b0;
    uart_en = 1'b1;
    for (int c = 0; c <= 2; c++) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pre: tx=%b expected 0 in start bit", tx);
    end
    n_rst = 1'b0; uart_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx, uart_done, uart_err, tx_busy} !== 4'b1000) begin
      errors++;
      $display("FAIL rst_mid: tx/done/err/busy=%b expected 1000", {tx, uart_done, uart_err, tx_busy});
    end
    n_rst = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      checks++;
      if ({tx, uart_done, uart_err} !== 3'b100) begin
        errors++;
        $display("FAIL rst_mid_quiet: tx/done/err=%b expected 100 at cycle %0d", {tx, uart_done, uart_err}, c);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_frame();
    test_two_stop();
    test_parity();
    test_cts_timeout();
    test_abort();
    test_reset_midframe();
    test_basic_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usi_uart_tx.md
# usi_uart_tx

UART transmit engine for the USI: the responder to the dispatcher's `uart_en`. It serializes one byte per enable window, honouring CTS flow control, and returns `uart_done` or `uart_err` so the dispatcher can leave its UART state. It sits between the USI dispatch FSM and the `tx` pad.

## Interface

- `CLKS_PER_BIT`, 16, clock cycles per serial bit; legal values are ≥ 2.
- `CTS_TIMEOUT`, 255, bit periods to wait for CTS before flagging an error; legal values are ≥ 1.
- `clk`  in  1  system clock; single clock domain.
- `n_rst`  in  1  reset; synchronous, active-low.
- `uart_en`  in  1  engine enable from the dispatcher; held high for the whole transaction.
- `tx_data`  in  8  byte to send; sampled when a frame starts.
- `stop2`  in  1  1 selects two stop bits, 0 selects one; sampled when a frame starts.
- `parity_odd`  in  1  parity sense, 1 for odd; only present under the macro.
- `cts_n`  in  1  clear-to-send, active-low.
- `tx`  out  1  serial line; idles high; registered.
- `uart_done`  out  1  one-cycle pulse when the frame completes.
- `uart_err`  out  1  one-cycle pulse on CTS timeout.
- `tx_busy`  out  1  high in START, DATA, PARITY and STOP.

## Operation

- Reset values: `tx`=1, `uart_done`=0, `uart_err`=0, `tx_busy`=0, state=IDLE, all counters 0.
- States: IDLE, WAIT_CTS, START, DATA, PARITY, STOP, DONE, HOLD.
- IDLE:
  - `uart_en`=1 and `cts_n`=0: latch `tx_data`, `stop2` and `parity_odd`; go to START.
  - `uart_en`=1 and `cts_n`=1: go to WAIT_CTS.
- WAIT_CTS:
  - Counts bit periods.
  - `cts_n`=0: latch the inputs and go to START.
  - Count reaches `CTS_TIMEOUT`: go to DONE with the error flag set.
- START: `tx`=0 for one bit period, then DATA.
- DATA:
  - 8 bits, LSB first, one bit period each.
  - A 3-bit index tracks the bit; after bit 7, go to PARITY if compiled in, otherwise STOP.
- PARITY: one bit period.
- STOP:
  - `tx`=1 for 1 or 2 bit periods, per the latched `stop2`.
  - Then go to DONE.
- DONE:
  - Lasts exactly one cycle.
  - Pulses `uart_done`, or `uart_err` if the error flag is set; the flag clears here.
  - Then go to HOLD.
- HOLD: `tx`=1; stays until `uart_en`=0, then IDLE. This prevents a resend before the dispatcher drops its enable.
- Abort: `uart_en`=0 in any state other than DONE/HOLD sends the block to IDLE at the next edge with `tx`=1. No done or error pulse is produced.
- `uart_done` and `uart_err` are never high in the same cycle.
- `cts_n` is ignored once START is entered; a byte in flight always completes.

## Timing

- Bit counter runs 0..`CLKS_PER_BIT`-1 with width `$clog2(CLKS_PER_BIT)`. A bit boundary is the cycle in which the counter equals `CLKS_PER_BIT`-1.
- `tx` falls at the first edge after `uart_en`=1 and `cts_n`=0 are sampled in IDLE.
- Frame length is (1 + 8 + P + S) × `CLKS_PER_BIT` cycles, where P is 0 or 1 and S is 1 or 2.
- `uart_done` rises at the edge ending the last stop-bit cycle and is high for one cycle.
- Worst-case CTS error latency is `CTS_TIMEOUT` × `CLKS_PER_BIT` + 1 cycles after entry to WAIT_CTS.
- `n_rst` low mid-frame: at the next edge `tx`=1, state=IDLE, and no pulses.

## Configuration

- `USI_UART_PARITY_EN`:
  - Defined: the `parity_odd` port and the PARITY state exist. The parity bit is XOR of the latched data bits, XOR `parity_odd`.
  - Undefined: no port, no state, P=0.

## Structure

- `usi_pkg` holds:
  - `uart_tx_state_t`, a 3-bit enum;
  - the mode constants `USI_MODE_UART`=2'b00, `USI_MODE_I2C`=2'b01, `USI_MODE_SPI`=2'b10, which are shared with the dispatcher.
- Sub-module `usi_baud_tick` holds the bit-period counter. It takes a `clear` input and produces a one-cycle `tick` every `CLKS_PER_BIT` cycles. It is cleared on every state entry.

## Test plan

- Basic frame: `CLKS_PER_BIT`=4, `tx_data`=8'hA5, `stop2`=0, CTS low, `uart_en` pulsed high.
  - `tx` = 0,1,0,1,0,0,1,0,1 (start bit, then data LSB first), then 1, with each bit 4 cycles.
  - `uart_done` pulses at cycle 40.
- Two stop bits: `stop2`=1 → `uart_done` pulses 4 cycles later than in the basic frame; `tx` stays high throughout the stop bits.
- CTS timeout: `cts_n`=1 held, `CTS_TIMEOUT`=3.
  - `uart_err` pulses once, after 12 cycles, and `tx` never leaves 1.
  - Then drop `uart_en` → state returns to IDLE.
- Abort: drop `uart_en` during DATA bit 3 → `tx`=1 at the next edge, and no done or error pulse.
- HOLD: keep `uart_en` high for 10 cycles after done → exactly one frame is sent.
- Parity (`USI_UART_PARITY_EN`): `tx_data`=8'h07 with `parity_odd`=0 → parity bit = 1.
- Reset: reset mid-frame → `tx`=1 at the next edge.
